// File: rtl/mem_write_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_write_seq_pkg : shared types and defaults for mem_write_sequencer      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_write_seq_pkg;

    localparam int c_def_fifo_depth = 4;
    localparam int c_def_setup_cyc  = 2;
    localparam int c_def_pulse_cyc  = 2;
    localparam int c_def_hold_cyc   = 1;
    // Phase counter width; phase lengths must stay below 2**c_cnt_w.
    localparam int c_cnt_w          = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_VERIFY = 3'd5
    } state_t;

    typedef struct packed {
        logic       clr;
        logic [3:0] addr;
        logic       data;
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/mem_write_seq_fifo.sv
// +----------------------------------------------------------------------------+
// | mem_write_seq_fifo : synchronous command FIFO, first-word-fall-through     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_write_seq_fifo
    import mem_write_seq_pkg::*;
#(
    parameter int DEPTH = c_def_fifo_depth
)(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t wr_cmd,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    localparam int c_aw = $clog2(DEPTH);

    cmd_t           r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;

    logic w_push;
    logic w_pop;

    assign full   = (r_count == (c_aw+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_cmd;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_write_sequencer.sv
// +----------------------------------------------------------------------------+
// | mem_write_sequencer : replays buffered write/clear commands as timed       |
// | setup/strobe/hold sequences on a 16x1 latch memory unit.                   |
// | Option macro: MEM_WRITE_SEQ_READBACK_EN (adds mem_q / wr_err, VERIFY)      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_write_sequencer
    import mem_write_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = c_def_fifo_depth,
    parameter int SETUP_CYC  = c_def_setup_cyc,
    parameter int PULSE_CYC  = c_def_pulse_cyc,
    parameter int HOLD_CYC   = c_def_hold_cyc
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_clr,
    input  logic [3:0]  req_addr,
    input  logic        req_data,
    output logic        mem_data,
    output logic [3:0]  mem_sl,
    output logic        mem_reclk,
    output logic        mem_rst,
`ifdef MEM_WRITE_SEQ_READBACK_EN
    input  logic [15:0] mem_q,
    output logic        wr_err,
`endif
    output logic        busy
);

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    cmd_t                r_cmd;

    cmd_t w_req_cmd;
    cmd_t w_head;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_drive;

    assign w_req_cmd = '{clr: req_clr, addr: req_addr, data: req_data};
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign req_ready = !w_full;
    assign busy      = (r_state != ST_IDLE) || !w_empty;
    assign w_drive   = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD);

    mem_write_seq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (req_valid),
        .wr_cmd (w_req_cmd),
        .pop    (w_pop),
        .head   (w_head),
        .full   (w_full),
        .empty  (w_empty)
    );

    // Pin values are a registered image of the state, so every pin lags the
    // state by one cycle and the phase lengths carry over unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cmd     <= '0;
            mem_data  <= 1'b0;
            mem_sl    <= 4'd0;
            mem_reclk <= 1'b0;
            mem_rst   <= 1'b0;
`ifdef MEM_WRITE_SEQ_READBACK_EN
            wr_err    <= 1'b0;
`endif
        end else begin
            mem_reclk <= (r_state == ST_STROBE);
            mem_rst   <= (r_state == ST_CLEAR);
            mem_data  <= w_drive && !r_cmd.clr && r_cmd.data;
            if (w_drive) begin
                mem_sl <= r_cmd.addr;
            end
`ifdef MEM_WRITE_SEQ_READBACK_EN
            wr_err    <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_cmd   <= w_head;
                        r_cnt   <= '0;
                        r_state <= w_head.clr ? ST_CLEAR : ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == c_cnt_w'(SETUP_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_STROBE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == c_cnt_w'(PULSE_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == c_cnt_w'(HOLD_CYC - 1)) begin
                        r_cnt   <= '0;
`ifdef MEM_WRITE_SEQ_READBACK_EN
                        r_state <= ST_VERIFY;
`else
                        r_state <= ST_IDLE;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == c_cnt_w'(PULSE_CYC - 1)) begin
                        r_cnt   <= '0;
`ifdef MEM_WRITE_SEQ_READBACK_EN
                        r_state <= ST_VERIFY;
`else
                        r_state <= ST_IDLE;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef MEM_WRITE_SEQ_READBACK_EN
                ST_VERIFY: begin
                    // Two settle cycles give the latch outputs time to reflect the write.
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        wr_err  <= r_cmd.clr ? (mem_q != 16'd0)
                                             : (mem_q[r_cmd.addr] != r_cmd.data);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_write_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_mem_write_sequencer : scoreboard bench for mem_write_sequencer          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_write_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int SETUP_CYC  = 2;
    localparam int PULSE_CYC  = 2;
    localparam int HOLD_CYC   = 1;

    typedef struct {
        logic       clr;
        logic [3:0] addr;
        logic       data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_clr = 1'b0;
    logic [3:0] req_addr = 4'd0;
    logic       req_data = 1'b0;
    logic       mem_data;
    logic [3:0] mem_sl;
    logic       mem_reclk;
    logic       mem_rst;
    logic       busy;
`ifdef MEM_WRITE_SEQ_READBACK_EN
    logic [15:0] mem_q;
    logic        wr_err;
    logic [15:0] r_cells = 16'd0;
    logic        stuck9 = 1'b0;
    assign mem_q = stuck9 ? (r_cells & ~16'h0200) : r_cells;
    // Latch memory model: strobe writes the selected cell, reset clears all.
    always @(posedge clk) begin
        if (mem_rst) r_cells <= 16'd0;
        else if (mem_reclk) r_cells[mem_sl] <= mem_data;
    end
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic saw_not_ready = 1'b0;

    always #5 clk = ~clk;

    mem_write_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SETUP_CYC  (SETUP_CYC),
        .PULSE_CYC  (PULSE_CYC),
        .HOLD_CYC   (HOLD_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_clr   (req_clr),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .mem_data  (mem_data),
        .mem_sl    (mem_sl),
        .mem_reclk (mem_reclk),
        .mem_rst   (mem_rst),
`ifdef MEM_WRITE_SEQ_READBACK_EN
        .mem_q     (mem_q),
        .wr_err    (wr_err),
`endif
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic c, input logic [3:0] a, input logic d);
        int guard = 0;
        req_valid = 1'b1;
        req_clr   = c;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && guard < 500) begin
            saw_not_ready = 1'b1;
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        exp_q.push_back('{clr: c, addr: a, data: d});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((busy || exp_q.size() != 0 || mem_reclk || mem_rst) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", (guard >= 2000) ? 32'd1 : 32'd0, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: turns pin activity into write/clear events and checks timing rules.
    logic [4:0] prev_sd, cap_sd, cur_sd;
    logic       prev_reclk, prev_mrst;
    int         stab, hi_cnt, rst_cnt, hold_left;
    exp_t       e;

    always @(negedge clk) begin
        if (rst) begin
            prev_sd = '0; cap_sd = '0; prev_reclk = 1'b0; prev_mrst = 1'b0;
            stab = 0; hi_cnt = 0; rst_cnt = 0; hold_left = 0;
        end else begin
            cur_sd = {mem_sl, mem_data};
            stab   = (cur_sd == prev_sd) ? stab + 1 : 1;
            if (mem_reclk && !prev_reclk) begin
                check("setup_cycles_ok", (stab - 1 >= SETUP_CYC) ? 32'd1 : 32'd0, 32'd1);
                cap_sd = cur_sd;
                hi_cnt = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_write", 32'(mem_reclk), 32'(!e.clr));
                    check("write_addr", 32'(mem_sl), 32'(e.addr));
                    check("write_data", 32'(mem_data), 32'(e.data));
                end
            end
            if (mem_reclk) begin
                hi_cnt++;
                check("sl_data_frozen", 32'(cur_sd), 32'(cap_sd));
                check("rst_low_in_strobe", 32'(mem_rst), 32'd0);
            end
            if (!mem_reclk && prev_reclk) begin
                check("strobe_width", 32'(hi_cnt), 32'(PULSE_CYC));
                hold_left = HOLD_CYC;
            end
            if (hold_left > 0) begin
                check("hold_stable", 32'(cur_sd), 32'(cap_sd));
                hold_left--;
            end
            if (mem_rst && !prev_mrst) begin
                rst_cnt = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_clear", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_clear", 32'(e.clr), 32'd1);
                end
            end
            if (mem_rst) begin
                rst_cnt++;
                check("data_low_in_clear", 32'(mem_data), 32'd0);
                check("reclk_low_in_clear", 32'(mem_reclk), 32'd0);
            end
            if (!mem_rst && prev_mrst) check("clear_width", 32'(rst_cnt), 32'(PULSE_CYC));
            prev_sd    = cur_sd;
            prev_reclk = mem_reclk;
            prev_mrst  = mem_rst;
        end
    end

    initial begin
        int lat;
        int gap;
        int guard;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_mem_sl", 32'(mem_sl), 32'd0);
        check("rst_mem_reclk", 32'(mem_reclk), 32'd0);
        check("rst_mem_rst", 32'(mem_rst), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);

        // Latency from accept to strobe rise on an empty FIFO
        send(1'b0, 4'd5, 1'b1);
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!mem_reclk && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("write_latency", 32'(lat), 32'(2 + SETUP_CYC));
        check("latency_sl", 32'(mem_sl), 32'd5);
        check("latency_data", 32'(mem_data), 32'd1);
        drain();
        check("data_returns_low", 32'(mem_data), 32'd0);
        check("sl_kept", 32'(mem_sl), 32'd5);

        // Burst of six back-to-back writes must back-pressure and lose nothing
        saw_not_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(1'b0, 4'(i + 8), 1'(i % 2));
        check("burst_backpressure", 32'(saw_not_ready), 32'd1);
        drain();

        // Clear following a write
        send(1'b0, 4'd3, 1'b1);
        send(1'b1, 4'd0, 1'b0);
        drain();

        // Reset during the strobe discards queued commands
        send(1'b0, 4'd1, 1'b1);
        send(1'b0, 4'd2, 1'b1);
        send(1'b1, 4'd0, 1'b0);
        guard = 0;
        while (!mem_reclk && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("strobe_seen_before_rst", 32'(mem_reclk), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_reclk", 32'(mem_reclk), 32'd0);
        check("abort_mem_rst", 32'(mem_rst), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_queue_dropped", 32'(busy), 32'd0);

        // Randomized traffic with random idle gaps
        for (int i = 0; i < 60; i++) begin
            send(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        drain();
        check("all_replayed", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

`ifdef MEM_WRITE_SEQ_READBACK_EN
        begin
            int errs = 0;
            stuck9 = 1'b1;
            send(1'b0, 4'd9, 1'b1);
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (wr_err) errs++;
            end
            check("wr_err_pulse", 32'(errs), 32'd1);
            stuck9 = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
